output_port_rr: RTL and testbench



---
 rtl/output_port_rr.sv | 152 +++++++++++++++
 tb/tb_output_port_rr.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_rr.sv
// output_port_rr: router output port with round-robin arbitration over matching inputs and an output FIFO.
// Define OUTPUT_PORT_WORMHOLE_EN to hold a grant from a packet's head flit through its tail flit.
module output_port_rr #(
    parameter int NUM_INPUTS   = 4,
    parameter int FLIT_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 2,
    parameter int PORT_ADDRESS = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_INPUTS*(ADDR_WIDTH+1+FLIT_WIDTH)-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]                           in_valid,
    output logic [NUM_INPUTS-1:0]                           in_block,
    output logic [FLIT_WIDTH:0]                             out_data,
    output logic                                            out_valid,
    input  logic                                            out_ready
);
    localparam int W     = ADDR_WIDTH + 1 + FLIT_WIDTH;
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_INPUTS-1:0] req;
    logic [FLIT_WIDTH:0]   flit [NUM_INPUTS];

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
        assign req[g]  = in_valid[g] &&
                         (in_data[g*W + FLIT_WIDTH + 1 +: ADDR_WIDTH] == ADDR_WIDTH'(PORT_ADDRESS));
        assign flit[g] = in_data[g*W +: FLIT_WIDTH + 1];
    end

    logic [FLIT_WIDTH:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    rr_winner;
    logic                rr_found;
    logic [IDX_W-1:0]    push_idx;
    logic                push;
    logic                pop;
    logic                space;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a flit when its head leaves in the same cycle.
    assign space     = (count < CNT_W'(FIFO_DEPTH)) || pop;

    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            if (!rr_found && req[(int'(last_grant) + k) % NUM_INPUTS]) begin
                rr_found  = 1'b1;
                rr_winner = IDX_W'((int'(last_grant) + k) % NUM_INPUTS);
            end
        end
    end

`ifdef OUTPUT_PORT_WORMHOLE_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
        owner <= owner_nxt;
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (push && !flit[push_idx][FLIT_WIDTH]) begin
                    state_nxt = ST_LOCKED;
                    owner_nxt = push_idx;
                end
            end
            ST_LOCKED: begin
                if (push && flit[push_idx][FLIT_WIDTH]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // While locked only the packet owner may move; an idle owner keeps the lock.
    always_comb begin
        push     = 1'b0;
        push_idx = (state == ST_LOCKED) ? owner : rr_winner;
        if (!reset && space) begin
            if (state == ST_LOCKED) begin
                push = req[owner];
            end else begin
                push = rr_found;
            end
        end
    end
`else
    always_comb begin
        push_idx = rr_winner;
        push     = !reset && space && rr_found;
    end
`endif

    always_comb begin
        in_block = req;
        if (push) begin
            in_block[push_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_grant <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                last_grant <= push_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= flit[push_idx];
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_output_port_rr.sv
// Self-checking bench for output_port_rr: directed scenarios plus randomized traffic against a queue-based model.
// Expected ordering adapts to OUTPUT_PORT_WORMHOLE_EN.
module tb_output_port_rr;
    localparam int N     = 4;
    localparam int FW    = 32;
    localparam int AW    = 2;
    localparam int PA    = 0;
    localparam int DEPTH = 4;
    localparam int W     = AW + 1 + FW;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_block;
    logic [FW:0]    out_data;
    logic           out_valid;
    logic           out_ready;

    always #5 clk = ~clk;

    output_port_rr #(
        .NUM_INPUTS(N), .FLIT_WIDTH(FW), .ADDR_WIDTH(AW),
        .PORT_ADDRESS(PA), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_block(in_block), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] src_q [N][$];
    logic [FW:0]  mq[$];
    logic [FW:0]  seen[$];
    int           m_last   = N - 1;
    bit           m_locked = 1'b0;
    int           m_owner  = 0;
    logic [N-1:0] blk_seen;

    function automatic logic [W-1:0] mk(int dest, bit tail, int src, int seq);
        logic [FW-1:0] pl;
        pl = {8'(src), 24'(seq)};
        return {AW'(dest), tail, pl};
    endfunction

    function automatic bit busy();
        bit b;
        b = (mq.size() > 0);
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    // One clock: compare DUT to model at negedge, advance model at posedge.
    task automatic step();
        logic [N-1:0] mreq;
        logic [N-1:0] exp_blk;
        logic [W-1:0] w;
        logic         ev;
        bit           pop;
        bit           space;
        int           win;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            w       = in_data[i*W +: W];
            mreq[i] = in_valid[i] && (w[W-1 -: AW] == AW'(PA));
        end
        pop   = (mq.size() > 0) && out_ready;
        space = (mq.size() < DEPTH) || pop;
        win   = -1;
        if (!reset && space) begin
            if (m_locked) begin
                if (mreq[m_owner]) win = m_owner;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (win < 0 && mreq[(m_last + k) % N]) win = (m_last + k) % N;
            end
        end
        exp_blk = mreq;
        if (win >= 0) exp_blk[win] = 1'b0;
        ev = (mq.size() > 0);
        n_checks++;
        if (in_block !== exp_blk) begin
            n_fail++;
            $display("FAIL in_block t=%0t got=%b want=%b", $time, in_block, exp_blk);
        end
        n_checks++;
        if (out_valid !== ev) begin
            n_fail++;
            $display("FAIL out_valid t=%0t got=%b want=%b", $time, out_valid, ev);
        end
        if (ev) begin
            n_checks++;
            if (out_data !== mq[0]) begin
                n_fail++;
                $display("FAIL out_data t=%0t got=%h want=%h", $time, out_data, mq[0]);
            end
        end
        blk_seen = in_block;
        if (out_valid && out_ready) seen.push_back(out_data);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_last   = N - 1;
            m_locked = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (win >= 0) begin
                w = in_data[win*W +: W];
                mq.push_back(w[FW:0]);
                m_last = win;
`ifdef OUTPUT_PORT_WORMHOLE_EN
                m_locked = !w[FW];
                m_owner  = win;
`endif
            end
        end
        #1;
    endtask

    // Present each channel's queue head; retire it once accepted (or if it targets another port).
    task automatic cycle();
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                in_valid[i]        = 1'b1;
                in_data[i*W +: W]  = src_q[i][0];
            end else begin
                in_valid[i]        = 1'b0;
                in_data[i*W +: W]  = '0;
            end
        end
        step();
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i]) begin
                    w = in_data[i*W +: W];
                    if (w[W-1 -: AW] != AW'(PA) || !blk_seen[i]) void'(src_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic drain(int maxc);
        int c = 0;
        out_ready = 1'b1;
        while (busy() && c < maxc) begin
            cycle();
            c++;
        end
        n_checks++;
        if (busy()) begin
            n_fail++;
            $display("FAIL drain_timeout cycles=%0d model_fifo=%0d want=0", c, mq.size());
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic do_reset();
        clear_src();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        seen.delete();
    endtask

    task automatic check_order(string name, int exp_src[$]);
        n_checks++;
        if (seen.size() != exp_src.size()) begin
            n_fail++;
            $display("FAIL %s_count got=%0d want=%0d", name, seen.size(), exp_src.size());
        end else begin
            for (int k = 0; k < exp_src.size(); k++) begin
                n_checks++;
                if (seen[k][FW-1 -: 8] !== 8'(exp_src[k])) begin
                    n_fail++;
                    $display("FAIL %s[%0d] got_src=%0d want_src=%0d", name, k, seen[k][FW-1 -: 8], exp_src[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].push_back(mk(PA, 1'b1, i, 0));
        cycle();
        n_checks++;
        if (blk_seen !== {N{1'b1}}) begin
            n_fail++;
            $display("FAIL reset_block got=%b want=%b", blk_seen, {N{1'b1}});
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out got_valid=%b got_data=%h want=0/0", out_valid, out_data);
        end
        do_reset();
    endtask

    task automatic test_single_flit();
        do_reset();
        out_ready = 1'b1;
        src_q[2].push_back(mk(PA, 1'b1, 2, 7));
        cycle();
        n_checks++;
        if (blk_seen !== '0) begin
            n_fail++;
            $display("FAIL single_block got=%b want=0000", blk_seen);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== {1'b1, 8'd2, 24'd7}) begin
            n_fail++;
            $display("FAIL single_out got=%b/%h want=1/%h", out_valid, out_data, {1'b1, 8'd2, 24'd7});
        end
        drain(10);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            src_q[0].push_back(mk(PA, 1'b1, 0, r));
            src_q[1].push_back(mk(PA, 1'b1, 1, r));
            src_q[3].push_back(mk(PA, 1'b1, 3, r));
        end
        drain(20);
        check_order("rr_order", '{0, 1, 3, 0, 1, 3});
    endtask

    task automatic test_wormhole();
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) src_q[1].push_back(mk(PA, f == 2, 1, f));
        cycle();
        src_q[0].push_back(mk(PA, 1'b1, 0, 0));
        src_q[0].push_back(mk(PA, 1'b1, 0, 1));
        drain(30);
`ifdef OUTPUT_PORT_WORMHOLE_EN
        check_order("worm_order", '{1, 1, 1, 0, 0});
`else
        check_order("worm_order", '{1, 0, 1, 0, 1});
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 20; s++) src_q[0].push_back(mk(PA, s == 19, 0, s));
        for (int c = 0; c < 6; c++) cycle();
        n_checks++;
        if (src_q[0].size() != 16 || blk_seen[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL full_stall accepted=%0d block=%b want=4/1", 20 - src_q[0].size(), blk_seen[0]);
        end
        drain(60);
        n_checks++;
        if (seen.size() != 20) begin
            n_fail++;
            $display("FAIL stream_count got=%0d want=20", seen.size());
        end else begin
            for (int s = 0; s < 20; s++) begin
                n_checks++;
                if (seen[s][23:0] !== 24'(s) || seen[s][FW] !== (s == 19)) begin
                    n_fail++;
                    $display("FAIL stream[%0d] got=%h want_seq=%0d", s, seen[s], s);
                end
            end
        end
    endtask

    task automatic test_dest_mismatch();
        do_reset();
        for (int k = 0; k < 5; k++) src_q[2].push_back(mk((PA + 1) % (1 << AW), 1'b1, 2, k));
        for (int k = 0; k < 3; k++) src_q[0].push_back(mk(PA, 1'b1, 0, k));
        drain(20);
        check_order("mismatch_order", '{0, 0, 0});
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++) src_q[0].push_back(mk(PA, f == 3, 0, f));
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_valid got=%b want=0", out_valid);
        end
        clear_src();
        seen.delete();
        src_q[3].push_back(mk(PA, 1'b1, 3, 0));
        src_q[1].push_back(mk(PA, 1'b1, 1, 0));
        src_q[0].push_back(mk(PA, 1'b1, 0, 0));
        drain(20);
        check_order("reset_mid_order", '{0, 1, 3});
    endtask

    task automatic test_random();
        int len;
        int dst;
        int seq = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 3);
                    dst = ($urandom_range(0, 4) == 0) ? (PA + 1 + $urandom_range(0, 2)) % (1 << AW) : PA;
                    for (int f = 0; f < len; f++) begin
                        src_q[i].push_back(mk(dst, f == len - 1, i, seq));
                        seq++;
                    end
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(200);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        blk_seen  = '0;
        #1;
        test_reset();
        test_single_flit();
        test_round_robin();
        test_wormhole();
        test_backpressure();
        test_dest_mismatch();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
